wb_burst_initiator: RTL and testbench
=====================================

# wb_burst_initiator

Wishbone B3 master-side initiator for a compute tile. It turns simple command, write-data and read-data streams into classic or incrementing-burst bus cycles on the tile `wb_bus_b3`. It handles ack, err and rty, and reports a per-command completion status. It is the initiating counterpart to the tile's Wishbone slave memories and accelerators; DMA engines and test masters use it to drive slave ports such as the on-tile RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bus data width; only 32 is supported.
- `ADDR_WIDTH`, 32, bus address width.
- `LEN_WIDTH`, 4, width of `cmd_len`; the maximum burst is 2^LEN_WIDTH beats.
- `MAX_RETRY`, 3, number of rty responses tolerated per beat before the command fails.

Ports:
- `clk`  in  1  single clock.
- `rst_sys`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  ADDR_WIDTH  start byte address.
- `cmd_sel`  in  4  byte select, applied to every beat.
- `cmd_len`  in  LEN_WIDTH  beats minus 1.
- `wdata`  in  32  write data.
- `wdata_valid`  in  1  write word offered.
- `wdata_ready`  out  1  write word consumed when both `wdata_valid` and `wdata_ready` are high.
- `rdata`  out  32  read data.
- `rdata_valid`  out  1  one-cycle strobe per read beat; no backpressure.
- `rdata_last`  out  1  marks the final read beat.
- `done_valid`  out  1  one-cycle completion pulse.
- `done_err`  out  1  command failed; valid with `done_valid`.
- `done_beats`  out  LEN_WIDTH+1  number of beats acked; valid with `done_valid`.
- `wbm_adr_o`  out  ADDR_WIDTH  bus address.
- `wbm_dat_o`  out  32  bus write data.
- `wbm_sel_o`  out  4  byte select.
- `wbm_cyc_o`  out  1  bus cycle.
- `wbm_stb_o`  out  1  strobe.
- `wbm_we_o`  out  1  write enable.
- `wbm_cti_o`  out  3  cycle type identifier.
- `wbm_bte_o`  out  2  burst type extension.
- `wbm_ack_i`  in  1  acknowledge.
- `wbm_err_i`  in  1  error.
- `wbm_rty_i`  in  1  retry.
- `wbm_dat_i`  in  32  bus read data.

## Operation
- States: IDLE, WDATA (write word pending), BUS (stb asserted), RETRY (one-cycle stb gap), DONE.
- IDLE: `cmd_ready`=1. On accept, the block latches adr, sel, we and len and clears the beat and retry counters.
  - Write command: next state is WDATA.
  - Read command: next state is BUS.
- WDATA: `cyc`=1, `stb`=0, `wdata_ready`=1. On accept, `wdata` is latched into `wbm_dat_o` and the next state is BUS.
- BUS: `cyc`=1, `stb`=1. Response priority is err > ack > rty; responses are sampled only while stb=1.
  - ack, not the last beat: address += 4 (mod 2^ADDR_WIDTH; `adr[1:0]` carried unchanged), beat count +1, retry count cleared.
    - Read: stay in BUS.
    - Write: `wdata_ready`=1 in this same cycle. If a word is accepted, stay in BUS with the new data; otherwise go to WDATA.
  - ack, last beat: go to DONE.
  - rty: retry count +1.
    - If the count after incrementing exceeds `MAX_RETRY`, go to DONE with error.
    - Otherwise go to RETRY, then back to BUS with the same address and data.
  - err: go to DONE with error; the remaining beats are abandoned.
- DONE: `cyc`=`stb`=0. `done_valid`=1, `done_beats` = acked beat count, `done_err` as determined. Next state is IDLE.
- On a read ack, `rdata` = `wbm_dat_i` and `rdata_valid`=1 in the same cycle (combinational pass-through). `rdata_last`=1 on the final beat.
- `wbm_cti_o`:
  - 3'b111 for single-beat commands and for the last beat of a burst.
  - 3'b010 otherwise.
- `wbm_bte_o` = 2'b00 (linear). `wbm_we_o` and `wbm_sel_o` are held constant for the whole command.
- On error, unconsumed write words remain upstream; the producer discards them using `done_beats`.

## Timing
- Reset values: `cmd_ready`=1 once out of reset (state IDLE). All other outputs are 0: `cyc`, `stb`, `we`, `adr`, `dat`, `sel`, `cti`, `bte`, `wdata_ready`, `rdata_valid`, `rdata_last`, `done_*`.
- Asserting `rst_sys` mid-burst drops `cyc`/`stb` immediately (asynchronously). No `done` pulse is issued.
- Read, command accepted in cycle 0:
  - `cyc`/`stb` are high from cycle 1.
  - With a zero-wait slave, beats ack in cycles 1..N.
  - `done_valid` is asserted in cycle N+1 and `cmd_ready` returns in cycle N+2.
- Write, command accepted in cycle 0 with `wdata` always valid:
  - WDATA occupies cycle 1 and `stb` rises in cycle 2.
  - Subsequent beats are back-to-back (ack plus same-cycle prefetch).
- `cyc` stays high without gaps for the whole command, including WDATA and RETRY cycles.
- `stb` is low for exactly one cycle after each rty.
- A command is never accepted while `done_valid` is high.

## Test plan
- Single read, `adr`=0x100, `len`=0, zero-wait slave -> one beat with `cti`=111; `rdata_valid` with `rdata_last`=1; `done_valid` with `err`=0 and `beats`=1 in cycle 2.
- 4-beat write burst, `adr`=0x200, `wdata` always valid -> addresses 0x200/204/208/20C on consecutive stb cycles; `cti` 010,010,010,111; `cyc` gapless; `done_beats`=4.
- 4-beat write with `wdata_valid` low for 3 cycles before beat 3 -> `stb` low for those cycles while `cyc` stays high; data order preserved.
- Read with slave rty twice on beat 2, then ack, `MAX_RETRY`=3 -> beat 2 re-presented at the same address after each one-cycle gap; no error; `done_beats`=4.
- err on beat 2 of a 4-beat read -> `cyc` low the next cycle; `done_err`=1, `done_beats`=1; `rdata_valid` asserted only once.
- `rst_sys` pulsed mid-burst -> `cyc`/`stb` low immediately and no `done`. `adr`=0xFFFFFFFC with `len`=1 -> second address is 0x00000000.

Source files
------------

// File: rtl/wb_burst_initiator_if.sv
// Wishbone B3 master-side bus bundle for wb_burst_initiator.
//
// Signals (names as seen from the initiator):
//   wbm_adr_o  address            wbm_dat_o  write data
//   wbm_sel_o  byte select        wbm_cyc_o  bus cycle
//   wbm_stb_o  strobe             wbm_we_o   write enable
//   wbm_cti_o  cycle type id      wbm_bte_o  burst type extension
//   wbm_ack_i  acknowledge        wbm_err_i  error
//   wbm_rty_i  retry              wbm_dat_i  read data
// Modports: master (initiator side), slave (target side).

interface wb_burst_initiator_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   wbm_adr_o;
  logic [DATA_WIDTH-1:0]   wbm_dat_o;
  logic [DATA_WIDTH/8-1:0] wbm_sel_o;
  logic                    wbm_cyc_o;
  logic                    wbm_stb_o;
  logic                    wbm_we_o;
  logic [2:0]              wbm_cti_o;
  logic [1:0]              wbm_bte_o;
  logic                    wbm_ack_i;
  logic                    wbm_err_i;
  logic                    wbm_rty_i;
  logic [DATA_WIDTH-1:0]   wbm_dat_i;

  modport master (
    output wbm_adr_o,
    output wbm_dat_o,
    output wbm_sel_o,
    output wbm_cyc_o,
    output wbm_stb_o,
    output wbm_we_o,
    output wbm_cti_o,
    output wbm_bte_o,
    input  wbm_ack_i,
    input  wbm_err_i,
    input  wbm_rty_i,
    input  wbm_dat_i
  );

  modport slave (
    input  wbm_adr_o,
    input  wbm_dat_o,
    input  wbm_sel_o,
    input  wbm_cyc_o,
    input  wbm_stb_o,
    input  wbm_we_o,
    input  wbm_cti_o,
    input  wbm_bte_o,
    output wbm_ack_i,
    output wbm_err_i,
    output wbm_rty_i,
    output wbm_dat_i
  );

endinterface

// File: rtl/wb_burst_initiator.sv
// Wishbone B3 burst initiator.
//
// Turns a command stream (cmd_*), a write-data stream (wdata*) and a read-data strobe
// (rdata*) into classic / incrementing-burst Wishbone cycles, handling ack, err and rty,
// and reports one completion pulse (done_*) per command.
//
// Ports:
//   clk, rst_sys                 clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_we/adr/sel/len   command stream (len = beats - 1)
//   wdata, wdata_valid/ready     write words, one per write beat
//   rdata, rdata_valid/last      read beats, combinational from the bus, no backpressure
//   done_valid/err/beats         one-cycle completion status
//   wbm                          Wishbone bus (master modport)

module wb_burst_initiator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_sys,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_adr,
  input  logic [3:0]            cmd_sel,
  input  logic [LEN_WIDTH-1:0]  cmd_len,

  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,

  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  rdata_last,

  output logic                  done_valid,
  output logic                  done_err,
  output logic [LEN_WIDTH:0]    done_beats,

  wb_burst_initiator_if.master  wbm
);

  localparam int unsigned BeatWidth  = LEN_WIDTH + 1;
  // Wide enough to hold MAX_RETRY + 1 without wrapping.
  localparam int unsigned RetryWidth = $clog2(MAX_RETRY + 2);
  localparam logic [RetryWidth-1:0] MaxRetry = RetryWidth'(MAX_RETRY);

  localparam logic [2:0] CtiIncr = 3'b010;
  localparam logic [2:0] CtiEnd  = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StBus,
    StRetry,
    StDone
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [3:0]              sel_q;
  logic                    we_q;
  logic                    cyc_q;
  logic                    stb_q;
  logic [2:0]              cti_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [BeatWidth-1:0]    beat_q;
  logic [RetryWidth-1:0]   retry_q;
  logic                    done_valid_q;
  logic                    done_err_q;
  logic [BeatWidth-1:0]    done_beats_q;

  logic                    in_bus;
  logic                    bus_err;
  logic                    bus_ack;
  logic                    bus_rty;
  logic                    last_beat;
  logic                    next_is_last;
  logic [BeatWidth-1:0]    beat_inc;
  logic [RetryWidth-1:0]   retry_inc;
  logic                    retry_exceeded;
  logic [ADDR_WIDTH-3:0]   adr_word_inc;
  logic [ADDR_WIDTH-1:0]   adr_next;

  // Responses only count while stb is up, i.e. in StBus; priority err > ack > rty.
  assign in_bus  = (state_q == StBus);
  assign bus_err = in_bus & wbm.wbm_err_i;
  assign bus_ack = in_bus & ~wbm.wbm_err_i & wbm.wbm_ack_i;
  assign bus_rty = in_bus & ~wbm.wbm_err_i & ~wbm.wbm_ack_i & wbm.wbm_rty_i;

  assign last_beat    = (beat_q == {1'b0, len_q});
  assign beat_inc     = beat_q + BeatWidth'(1);
  assign next_is_last = (beat_inc == {1'b0, len_q});

  assign retry_inc      = retry_q + RetryWidth'(1);
  assign retry_exceeded = (retry_inc > MaxRetry);

  // Word-increment the address; the byte offset bits ride along untouched.
  assign adr_word_inc = adr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);
  assign adr_next     = {adr_word_inc, adr_q[1:0]};

  assign cmd_ready = (state_q == StIdle);

  // Write data is also pulled in the ack cycle of a non-final beat so the next beat can
  // follow back-to-back.
  assign wdata_ready = (state_q == StWdata) | (bus_ack & we_q & ~last_beat);

  assign rdata_valid = bus_ack & ~we_q;
  assign rdata_last  = rdata_valid & last_beat;
  assign rdata       = rdata_valid ? wbm.wbm_dat_i : '0;

  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;
  assign done_beats = done_beats_q;

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = stb_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_cti_o = cti_q;
  assign wbm.wbm_bte_o = 2'b00;

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      cti_q        <= 3'b000;
      len_q        <= '0;
      beat_q       <= '0;
      retry_q      <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_beats_q <= '0;
    end else begin
      // Completion outputs are a single-cycle pulse.
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_beats_q <= '0;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            adr_q   <= cmd_adr;
            sel_q   <= cmd_sel;
            we_q    <= cmd_we;
            len_q   <= cmd_len;
            beat_q  <= '0;
            retry_q <= '0;
            cyc_q   <= 1'b1;
            cti_q   <= (cmd_len == '0) ? CtiEnd : CtiIncr;
            if (cmd_we) begin
              stb_q   <= 1'b0;
              state_q <= StWdata;
            end else begin
              stb_q   <= 1'b1;
              state_q <= StBus;
            end
          end
        end

        StWdata: begin
          if (wdata_valid) begin
            dat_q   <= wdata;
            stb_q   <= 1'b1;
            state_q <= StBus;
          end
        end

        StBus: begin
          if (bus_err) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            cti_q        <= 3'b000;
            done_valid_q <= 1'b1;
            done_err_q   <= 1'b1;
            done_beats_q <= beat_q;
            state_q      <= StDone;
          end else if (bus_ack) begin
            beat_q <= beat_inc;
            if (last_beat) begin
              cyc_q        <= 1'b0;
              stb_q        <= 1'b0;
              cti_q        <= 3'b000;
              done_valid_q <= 1'b1;
              done_beats_q <= beat_inc;
              state_q      <= StDone;
            end else begin
              adr_q   <= adr_next;
              retry_q <= '0;
              cti_q   <= next_is_last ? CtiEnd : CtiIncr;
              if (we_q) begin
                if (wdata_valid) begin
                  dat_q <= wdata;
                end else begin
                  stb_q   <= 1'b0;
                  state_q <= StWdata;
                end
              end
            end
          end else if (bus_rty) begin
            retry_q <= retry_inc;
            stb_q   <= 1'b0;
            if (retry_exceeded) begin
              cyc_q        <= 1'b0;
              cti_q        <= 3'b000;
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
              done_beats_q <= beat_q;
              state_q      <= StDone;
            end else begin
              state_q <= StRetry;
            end
          end
        end

        // One-cycle strobe gap, then re-present the same address and data.
        StRetry: begin
          stb_q   <= 1'b1;
          state_q <= StBus;
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          cyc_q   <= 1'b0;
          stb_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_initiator.sv
module tb_wb_burst_initiator;

  localparam int unsigned LW = 4;
  localparam int          MaxRetry = 3;

  logic          clk = 1'b0;
  logic          rst_sys = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [31:0]   cmd_adr = '0;
  logic [3:0]    cmd_sel = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [31:0]   wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          rdata_last;
  logic          done_valid;
  logic          done_err;
  logic [LW:0]   done_beats;

  wb_burst_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) wbm_if ();

  wb_burst_initiator #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LEN_WIDTH (LW),
    .MAX_RETRY (MaxRetry)
  ) dut (
    .clk        (clk),
    .rst_sys    (rst_sys),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_sel    (cmd_sel),
    .cmd_len    (cmd_len),
    .wdata      (wdata),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .rdata_last (rdata_last),
    .done_valid (done_valid),
    .done_err   (done_err),
    .done_beats (done_beats),
    .wbm        (wbm_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } rd_t;

  typedef struct {
    logic        err;
    logic [LW:0] beats;
    int          lat;
  } done_t;

  typedef struct {
    logic [31:0] dat;
    int          gap;
  } wd_t;

  beat_t exp_beat[$];
  rd_t   exp_rd[$];
  done_t exp_done[$];
  wd_t   wd_q[$];
  int    resp_q[$];   // slave script, one code per stb cycle: 0 ack, 1 rty, 2 err

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int cmd_cycle = 0;
  int low_cnt = 0;
  int gap_cnt = 0;
  int cmd_id = 0;
  bit in_cmd = 1'b0;
  bit done_seen = 1'b0;
  bit flush_req = 1'b0;
  bit wd_pending = 1'b0;
  bit rty_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] wd_word(input int id, input int k);
    return 32'hC0DE_0000 | 32'(id << 8) | 32'(k);
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Write producer, zero-wait slave with scripted responses, and output monitor.
  always @(negedge clk) begin
    int    code;
    beat_t b;
    rd_t   r;
    done_t d;
    if (flush_req) begin
      wd_q.delete();
      resp_q.delete();
      wd_pending = 1'b0;
      gap_cnt = 0;
      flush_req = 1'b0;
    end
    if (wd_pending) begin
      if (wd_q.size() > 0) void'(wd_q.pop_front());
      wd_pending = 1'b0;
      gap_cnt = 0;
    end
    if (wd_q.size() > 0) begin
      if (gap_cnt < wd_q[0].gap) begin
        wdata_valid = 1'b0;
        gap_cnt++;
      end else begin
        wdata_valid = 1'b1;
        wdata = wd_q[0].dat;
      end
    end else begin
      wdata_valid = 1'b0;
    end

    if (wbm_if.wbm_stb_o) begin
      code = 0;
      if (resp_q.size() > 0) code = resp_q.pop_front();
      wbm_if.wbm_ack_i = (code == 0);
      wbm_if.wbm_rty_i = (code == 1);
      wbm_if.wbm_err_i = (code == 2);
      wbm_if.wbm_dat_i = mem_word(wbm_if.wbm_adr_o);
    end else begin
      wbm_if.wbm_ack_i = 1'b0;
      wbm_if.wbm_rty_i = 1'b0;
      wbm_if.wbm_err_i = 1'b0;
      wbm_if.wbm_dat_i = '0;
    end

    #1;
    if (wbm_if.wbm_stb_o) begin
      if (exp_beat.size() == 0) begin
        check_eq("stb_unexpected", {63'd0, wbm_if.wbm_stb_o}, 64'd0);
      end else begin
        b = exp_beat.pop_front();
        check_eq("beat_adr", {32'd0, wbm_if.wbm_adr_o}, {32'd0, b.adr});
        check_eq("beat_cti", {61'd0, wbm_if.wbm_cti_o}, {61'd0, b.cti});
        check_eq("beat_we_sel_bte", {57'd0, wbm_if.wbm_we_o, wbm_if.wbm_sel_o, wbm_if.wbm_bte_o},
                 {57'd0, b.we, b.sel, 2'b00});
        if (b.we) check_eq("beat_wdat", {32'd0, wbm_if.wbm_dat_o}, {32'd0, b.dat});
      end
    end
    if (rdata_valid) begin
      if (exp_rd.size() == 0) begin
        check_eq("rdata_unexpected", {63'd0, rdata_valid}, 64'd0);
      end else begin
        r = exp_rd.pop_front();
        check_eq("rdata", {32'd0, rdata}, {32'd0, r.dat});
        check_eq("rdata_last", {63'd0, rdata_last}, {63'd0, r.last});
      end
    end
    if (done_valid) begin
      if (exp_done.size() == 0) begin
        check_eq("done_unexpected", {63'd0, done_valid}, 64'd0);
      end else begin
        d = exp_done.pop_front();
        check_eq("done_err", {63'd0, done_err}, {63'd0, d.err});
        check_eq("done_beats", {59'd0, done_beats}, {59'd0, d.beats});
        if (d.lat >= 0) check_eq("done_latency", 64'(cyc_n - cmd_cycle), 64'(d.lat));
        check_eq("cyc_at_done", {63'd0, wbm_if.wbm_cyc_o}, 64'd0);
        check_eq("cmd_ready_at_done", {63'd0, cmd_ready}, 64'd0);
      end
      done_seen = 1'b1;
      in_cmd = 1'b0;
    end else if (in_cmd) begin
      check_eq("cyc_gapless", {63'd0, wbm_if.wbm_cyc_o}, 64'd1);
      if (!wbm_if.wbm_stb_o) low_cnt++;
    end
    if (rty_prev) check_eq("stb_gap_after_rty", {63'd0, wbm_if.wbm_stb_o}, 64'd0);
    rty_prev = wbm_if.wbm_stb_o & wbm_if.wbm_rty_i & ~wbm_if.wbm_ack_i & ~wbm_if.wbm_err_i;
    wd_pending = wdata_valid & wdata_ready;
  end

  // Builds expectations from the slave script already in resp_q, issues the command, then
  // either waits for completion or pulses reset after rst_after cycles.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input int len, input int gap_beat, input int gap_len,
                         input int lat, input int low_exp, input int rst_after);
    int          script[$];
    int          idx;
    int          beat;
    int          rc;
    int          code;
    logic [31:0] a;
    logic        err;
    logic        fin;
    beat_t       b;
    rd_t         r;
    done_t       d;
    wd_t         w;
    script = resp_q;
    cmd_id++;
    if (we) begin
      for (int k = 0; k <= len; k++) begin
        w.dat = wd_word(cmd_id, k);
        w.gap = (k == gap_beat) ? gap_len : 0;
        wd_q.push_back(w);
      end
    end
    idx = 0; beat = 0; rc = 0; a = adr; err = 1'b0; fin = 1'b0;
    while (!fin) begin
      code = (idx < script.size()) ? script[idx] : 0;
      idx++;
      b.adr = a; b.we = we; b.sel = sel; b.dat = wd_word(cmd_id, beat);
      b.cti = (beat == len) ? 3'b111 : 3'b010;
      exp_beat.push_back(b);
      if (code == 2) begin
        err = 1'b1; fin = 1'b1;
      end else if (code == 1) begin
        rc++;
        if (rc > MaxRetry) begin
          err = 1'b1; fin = 1'b1;
        end
      end else begin
        if (!we) begin
          r.dat = mem_word(a); r.last = (beat == len);
          exp_rd.push_back(r);
        end
        beat++; rc = 0;
        if (beat == len + 1) fin = 1'b1;
        else a = {a[31:2] + 30'd1, a[1:0]};
      end
    end
    d.err = err; d.beats = (LW + 1)'(beat); d.lat = lat;
    exp_done.push_back(d);

    @(negedge clk); #2;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(negedge clk); #2;
    end
    check_eq("cmd_ready_before_issue", {63'd0, cmd_ready}, 64'd1);
    cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = LW'(len);
    cmd_valid = 1'b1;
    cmd_cycle = cyc_n;
    low_cnt = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_cmd = 1'b1;

    if (rst_after > 0) begin
      repeat (rst_after) @(negedge clk);
      #3 rst_sys = 1'b1;
      #1;
      check_eq("rst_cyc_drop", {63'd0, wbm_if.wbm_cyc_o}, 64'd0);
      check_eq("rst_stb_drop", {63'd0, wbm_if.wbm_stb_o}, 64'd0);
      exp_beat.delete(); exp_rd.delete(); exp_done.delete();
      in_cmd = 1'b0;
      flush_req = 1'b1;
      repeat (3) @(negedge clk);
      #3 rst_sys = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check_eq("no_done_after_rst", {63'd0, done_seen}, 64'd0);
      check_eq("cmd_ready_after_rst", {63'd0, cmd_ready}, 64'd1);
    end else begin
      for (int i = 0; i < 200 && !done_seen; i++) begin
        @(negedge clk); #2;
      end
      check_eq("done_timeout", {63'd0, done_seen}, 64'd1);
      check_eq("beats_left", 64'(exp_beat.size()), 64'd0);
      check_eq("rdata_left", 64'(exp_rd.size()), 64'd0);
      if (low_exp >= 0) check_eq("stb_low_cycles", 64'(low_cnt), 64'(low_exp));
      exp_beat.delete(); exp_rd.delete(); exp_done.delete();
      in_cmd = 1'b0;
      flush_req = 1'b1;
      @(negedge clk); #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_sys = 1'b0;
    @(negedge clk); #2;
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_adr", {32'd0, wbm_if.wbm_adr_o}, 64'd0);
    check_eq("rst_dat", {32'd0, wbm_if.wbm_dat_o}, 64'd0);
    check_eq("rst_bus_ctl", {52'd0, wbm_if.wbm_cyc_o, wbm_if.wbm_stb_o, wbm_if.wbm_we_o,
             wbm_if.wbm_sel_o, wbm_if.wbm_cti_o, wbm_if.wbm_bte_o}, 64'd0);
    check_eq("rst_streams", {54'd0, wdata_ready, rdata_valid, rdata_last, done_valid,
             done_err, done_beats}, 64'd0);

    // Single read: done in cycle 2.
    run_cmd(1'b0, 32'h0000_0100, 4'hF, 0, -1, 0, 2, 0, 0);
    // 4-beat read, zero-wait.
    run_cmd(1'b0, 32'h0000_0400, 4'hF, 3, -1, 0, 5, 0, 0);
    // 4-beat write, data always valid.
    run_cmd(1'b1, 32'h0000_0200, 4'hF, 3, -1, 0, 6, 1, 0);
    // 4-beat write, producer stalls 3 cycles before beat 3.
    run_cmd(1'b1, 32'h0000_0300, 4'hF, 3, 2, 3, 9, 4, 0);
    // Two rty on beat 2, then acks.
    resp_q = '{0, 1, 1, 0, 0, 0};
    run_cmd(1'b0, 32'h0000_0500, 4'hF, 3, -1, 0, 9, 2, 0);
    // err on beat 2 of a 4-beat read.
    resp_q = '{0, 2};
    run_cmd(1'b0, 32'h0000_0600, 4'hF, 3, -1, 0, 3, -1, 0);
    // rty beyond MAX_RETRY fails with no beats.
    resp_q = '{1, 1, 1, 1};
    run_cmd(1'b0, 32'h0000_0700, 4'hF, 0, -1, 0, 8, 3, 0);
    // Reset in the middle of an 8-beat read.
    run_cmd(1'b0, 32'h0000_0800, 4'hF, 7, -1, 0, -1, -1, 3);
    // Address wrap at the top of the space.
    run_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 1, -1, 0, 3, 0, 0);
    // Unaligned start, partial byte select.
    run_cmd(1'b1, 32'h0000_1002, 4'h3, 1, -1, 0, -1, 1, 0);
    // Maximum burst length.
    run_cmd(1'b0, 32'h0000_2000, 4'hF, 15, -1, 0, 17, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
